// File: rtl/barrier_column_gen.sv
// barrier_column_gen: emits one playfield column per scroll tick, alternating a
// run of empty columns with a wall that has a pseudo-random gap. The gap shrinks
// as walls are passed, and a saturating count of completed walls feeds the score.
module barrier_column_gen #(
  parameter int          ROWS       = 8,
  parameter int          GAP_MAX    = 4,
  parameter int          GAP_MIN    = 2,
  parameter int          SPACING    = 4,
  parameter int          WALL_W     = 1,
  parameter int          LEVEL_STEP = 4,
  parameter int          COUNT_W    = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   advance,
  output logic [ROWS-1:0]        column,
  output logic                   col_valid,
  output logic                   is_wall,
  output logic [$clog2(ROWS):0]  gap_size,
  output logic [COUNT_W-1:0]     barrier_count
);

  localparam int PW = $clog2(ROWS);
  localparam int GW = PW + 1;
  localparam int SW = $clog2(SPACING + 1);
  localparam int WW = $clog2(WALL_W + 1);
  localparam int LW = $clog2(LEVEL_STEP + 1);

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPACE = 2'd1,
    WALL  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [SW-1:0]      space_cnt, space_cnt_n;
  logic [WW-1:0]      wall_cnt, wall_cnt_n;
  logic [LW-1:0]      level_cnt, level_cnt_n;
  logic [GW-1:0]      pos, pos_n;
  logic [GW-1:0]      pos_clamped;
  logic [GW-1:0]      pos_limit;
  logic [GW-1:0]      pos_raw;
  logic [15:0]        lfsr;
  logic [ROWS-1:0]    column_n;
  logic               col_valid_n;
  logic               is_wall_n;
  logic [GW-1:0]      gap_size_n;
  logic [COUNT_W-1:0] barrier_count_n;

  // One Galois LFSR step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // Wall column: rows [p, p+g) are the opening (0), every other row is lit (1).
  function automatic logic [ROWS-1:0] wall_pattern(input logic [GW-1:0] p,
                                                   input logic [GW-1:0] g);
    logic [ROWS-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      m[r] = !((r >= int'(p)) && (r < int'(p) + int'(g)));
    end
    return m;
  endfunction

  // Gap origin from the LFSR, pulled down so the opening never runs off the top.
  always_comb begin
    pos_raw     = GW'(lfsr[PW-1:0]);
    pos_limit   = GW'(ROWS) - gap_size;
    pos_clamped = (pos_raw > pos_limit) ? pos_limit : pos_raw;
  end

  // LFSR free-runs on every clock so player timing perturbs the gap sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-output logic; advance only counts once the FSM is out of IDLE.
  always_comb begin
    state_n         = state;
    space_cnt_n     = space_cnt;
    wall_cnt_n      = wall_cnt;
    level_cnt_n     = level_cnt;
    pos_n           = pos;
    column_n        = column;
    col_valid_n     = 1'b0;
    is_wall_n       = is_wall;
    gap_size_n      = gap_size;
    barrier_count_n = barrier_count;

    if (!enable) begin
      state_n   = IDLE;
      column_n  = '0;
      is_wall_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n     = SPACE;
          space_cnt_n = '0;
        end
        SPACE: begin
          if (advance) begin
            column_n    = '0;
            is_wall_n   = 1'b0;
            col_valid_n = 1'b1;
            if (space_cnt == SW'(SPACING - 1)) begin
              state_n    = WALL;
              wall_cnt_n = '0;
              pos_n      = pos_clamped;
            end else begin
              space_cnt_n = space_cnt + SW'(1);
            end
          end
        end
        WALL: begin
          if (advance) begin
            column_n    = wall_pattern(pos, gap_size);
            is_wall_n   = 1'b1;
            col_valid_n = 1'b1;
            if (wall_cnt == WW'(WALL_W - 1)) begin
              state_n         = SPACE;
              space_cnt_n     = '0;
              barrier_count_n = sat_inc(barrier_count);
              if (level_cnt == LW'(LEVEL_STEP - 1)) begin
                level_cnt_n = '0;
                if (gap_size > GW'(GAP_MIN)) begin
                  gap_size_n = gap_size - GW'(1);
                end
              end else begin
                level_cnt_n = level_cnt + LW'(1);
              end
            end else begin
              wall_cnt_n = wall_cnt + WW'(1);
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Registered column output, counters and difficulty state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      space_cnt     <= '0;
      wall_cnt      <= '0;
      level_cnt     <= '0;
      pos           <= '0;
      column        <= '0;
      col_valid     <= 1'b0;
      is_wall       <= 1'b0;
      gap_size      <= GW'(GAP_MAX);
      barrier_count <= '0;
    end else begin
      space_cnt     <= space_cnt_n;
      wall_cnt      <= wall_cnt_n;
      level_cnt     <= level_cnt_n;
      pos           <= pos_n;
      column        <= column_n;
      col_valid     <= col_valid_n;
      is_wall       <= is_wall_n;
      gap_size      <= gap_size_n;
      barrier_count <= barrier_count_n;
    end
  end

endmodule

// File: tb/tb_barrier_column_gen.sv
// Bench for barrier_column_gen: a column-sequence reference model (period of
// SPACING empty columns plus WALL_W wall columns per enable run) predicts every
// output cycle by cycle for the default build and a 2-bit-count build.
module tb_barrier_column_gen;

  localparam int ROWS       = 8;
  localparam int GAP_MAX    = 4;
  localparam int GAP_MIN    = 2;
  localparam int SPACING    = 4;
  localparam int WALL_W     = 1;
  localparam int LEVEL_STEP = 4;
  localparam int PERIOD     = SPACING + WALL_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic advance = 1'b0;

  logic [7:0] column, column2;
  logic       col_valid, col_valid2;
  logic       is_wall, is_wall2;
  logic [3:0] gap_size, gap_size2;
  logic [7:0] barrier_count;
  logic [1:0] barrier_count2;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [15:0] m_lfsr;
  int          m_run;
  int          m_walls;
  int          m_pos;
  logic        m_prev_en;
  logic [7:0]  e_col;
  logic        e_valid;
  logic        e_wall;

  always #5 clk = ~clk;

  barrier_column_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .advance(advance),
    .column(column), .col_valid(col_valid), .is_wall(is_wall),
    .gap_size(gap_size), .barrier_count(barrier_count)
  );

  barrier_column_gen #(.COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .advance(advance),
    .column(column2), .col_valid(col_valid2), .is_wall(is_wall2),
    .gap_size(gap_size2), .barrier_count(barrier_count2)
  );

  function automatic int gap_of(input int walls);
    int g;
    g = GAP_MAX - walls / LEVEL_STEP;
    return (g < GAP_MIN) ? GAP_MIN : g;
  endfunction

  function automatic logic [7:0] pattern(input int p, input int g);
    logic [7:0] hole;
    hole = 8'((1 << g) - 1) << p;
    return 8'hFF ^ hole;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr    = 16'hACE1;
    m_run     = 0;
    m_walls   = 0;
    m_pos     = 0;
    m_prev_en = 1'b0;
    e_col     = 8'h00;
    e_valid   = 1'b0;
    e_wall    = 1'b0;
  endtask

  // One clock edge of the reference model, using pre-edge inputs and LFSR value.
  task automatic model_edge(input logic en, input logic adv);
    int  k;
    logic acc;
    acc = en && m_prev_en && adv;
    if (!en) begin
      m_run  = 0;
      e_col  = 8'h00;
      e_wall = 1'b0;
    end else if (acc) begin
      k = m_run % PERIOD;
      if (k < SPACING) begin
        e_col  = 8'h00;
        e_wall = 1'b0;
        if (k == SPACING - 1)
          m_pos = imin(int'(m_lfsr[2:0]), ROWS - gap_of(m_walls));
      end else begin
        e_col  = pattern(m_pos, gap_of(m_walls));
        e_wall = 1'b1;
        if (k == PERIOD - 1) m_walls++;
      end
      m_run++;
    end
    e_valid   = acc;
    m_prev_en = en;
    m_lfsr    = lfsr_next(m_lfsr);
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".column"},    column,         e_col);
    chk({ctx, ".col_valid"}, col_valid,      e_valid);
    chk({ctx, ".is_wall"},   is_wall,        e_wall);
    chk({ctx, ".gap_size"},  gap_size,       gap_of(m_walls));
    chk({ctx, ".count"},     barrier_count,  imin(m_walls, 255));
    chk({ctx, ".column2"},   column2,        e_col);
    chk({ctx, ".valid2"},    col_valid2,     e_valid);
    chk({ctx, ".count2"},    barrier_count2, imin(m_walls, 3));
  endtask

  task automatic step(input string ctx, input logic en, input logic adv);
    enable  = en;
    advance = adv;
    @(posedge clk);
    model_edge(en, adv);
    #1;
    check_all(ctx);
  endtask

  initial begin
    int   i;
    logic [7:0] saved_cnt;

    // reset state
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    #2 reset = 1'b1;

    // enable rising together with advance: advance dropped
    step("en_rise", 1'b1, 1'b1);
    chk("en_rise_novalid", col_valid, 1'b0);

    // five advances: four empty columns, then a wall
    for (int n = 0; n < 5; n++) step("first5", 1'b1, 1'b1);
    chk("first5_wall", is_wall, 1'b1);
    step("gap_after_adv", 1'b1, 1'b0);
    chk("valid_one_cycle", col_valid, 1'b0);

    // clamp: wait for an LFSR sample with low bits 7 at the pos-latch advance
    i = 0;
    while ((m_run % PERIOD) != SPACING - 1 && i < 20) begin
      step("to_sample", 1'b1, 1'b1);
      i++;
    end
    i = 0;
    while (m_lfsr[2:0] != 3'd7 && i < 300) begin
      step("wait_lfsr7", 1'b1, 1'b0);
      i++;
    end
    chk("lfsr7_timeout", (m_lfsr[2:0] == 3'd7), 1'b1);
    step("clamp_sample", 1'b1, 1'b1);
    step("clamp_wall", 1'b1, 1'b1);
    chk("clamp_col", column, 8'h0F);

    // difficulty ramp to 16 walls with advance every cycle
    i = 0;
    while (m_walls < 16 && i < 200) begin
      step("ramp", 1'b1, 1'b1);
      i++;
    end
    chk("ramp_gap", gap_size, 4'd2);
    chk("ramp_count", barrier_count, 8'd16);
    chk("sat_count2", barrier_count2, 2'd3);

    // drop enable while in WALL; advances ignored; re-enable restarts spacing
    i = 0;
    while ((m_run % PERIOD) != SPACING && i < 20) begin
      step("to_wall", 1'b1, 1'b1);
      i++;
    end
    saved_cnt = barrier_count;
    for (int n = 0; n < 3; n++) begin
      step("disabled", 1'b0, 1'b1);
      chk("disabled_valid", col_valid, 1'b0);
      chk("disabled_col", column, 8'h00);
    end
    chk("disabled_count", barrier_count, saved_cnt);
    step("reenable", 1'b1, 1'b0);
    for (int n = 0; n < 4; n++) begin
      step("respace", 1'b1, 1'b1);
      chk("respace_empty", is_wall, 1'b0);
    end
    step("rewall", 1'b1, 1'b1);
    chk("rewall_is_wall", is_wall, 1'b1);

    // advance with enable low from IDLE: no output change
    step("idle_adv", 1'b0, 1'b1);
    step("idle_adv", 1'b0, 1'b1);

    // randomized enable/advance traffic
    for (int n = 0; n < 1500; n++)
      step("rand", ($urandom % 20) != 0, ($urandom % 4) != 0);

    // asynchronous reset in the middle of a wall, sampled before any clock edge
    i = 0;
    while (!(e_wall && enable) && i < 40) begin
      step("to_wall2", 1'b1, 1'b1);
      i++;
    end
    chk("pre_reset_wall", is_wall, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_column", column, 8'h00);
    chk("async_is_wall", is_wall, 1'b0);
    chk("async_gap", gap_size, 4'd4);
    chk("async_count", barrier_count, 8'd0);
    chk("async_count2", barrier_count2, 2'd0);
    chk("async_valid", col_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
